// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Redirect targets are forced onto a word boundary before use.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID holding register with
// valid/ready handshake, redirect handling and a transfer counter.
module if_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         transfer;
  logic         capture;

  assign imem_addr = pc;
  assign transfer  = id_valid && id_ready;
  assign capture   = (state == FETCH) && fetch_en && (!id_valid || id_ready)
                     && !redirect_valid;

  // A redirect wins over capture; a transfer on the same edge is still counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      id_valid     <= 1'b0;
      id_pc        <= 32'h0000_0000;
      id_instr     <= NOP_INSTR;
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0000_0000;
    end else begin
      state <= fetch_en ? FETCH : IDLE;
      if (transfer) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect_valid) begin
        pc       <= align_word(redirect_pc);
        id_valid <= 1'b0;
        if (is_misaligned(redirect_pc)) begin
          misalign_err <= 1'b1;
        end
      end else if (capture) begin
        id_instr <= imem_instr;
        id_pc    <= pc;
        id_valid <= 1'b1;
        pc       <= pc + PC_STEP;
      end else if (transfer) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed scoreboard bench for if_stage, including a second instance
// with a reset PC near the top of the address space.
module tb_if_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic [31:0] imem_addr, imem_instr, id_pc, id_instr, fetch_count;
  logic        id_valid, misalign_err;

  logic [31:0] w_imem_addr, w_imem_instr, w_id_pc, w_id_instr, w_fetch_count;
  logic        w_id_valid, w_misalign_err;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Instruction ROM contents: the three listed words, then a distinct pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_0113;
      default:       return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign imem_instr   = rom_word(imem_addr);
  assign w_imem_instr = rom_word(w_imem_addr);

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(w_id_valid), .id_ready(id_ready), .id_pc(w_id_pc), .id_instr(w_id_instr),
    .misalign_err(w_misalign_err), .fetch_count(w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic rdy,
                               input logic rv, input logic [31:0] rp);
    rst_n          = r;
    fetch_en       = f;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom_word(pc);
    exp_q.push_back(e);
  endtask

  // An entry about to be accepted by decode is popped and compared.
  task automatic checkOutput();
    exp_t e;
    if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL sb_underflow observed id_pc=%h expected=no_entry", id_pc);
      end else begin
        e = exp_q.pop_front();
        check32("sb_pc", id_pc, e.pc);
        check32("sb_instr", id_instr, e.instr);
      end
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check32("rst_valid", {31'b0, id_valid}, 32'd0);
    check32("rst_pc", id_pc, 32'h0);
    check32("rst_instr", id_instr, 32'h0000_0013);
    check32("rst_misalign", {31'b0, misalign_err}, 32'd0);
    check32("rst_count", fetch_count, 32'd0);
    check32("rst_addr", imem_addr, 32'h0);

    // Streaming fetch with decode always ready.
    $display("[TB] streaming fetch");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    step();
    check32("first_latency_valid", {31'b0, id_valid}, 32'd0);
    checkOutput();
    step();
    checkOutput();
    step();
    checkOutput();
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput();
    check32("count_two", fetch_count, 32'd2);
    check32("addr_next", imem_addr, 32'hC);

    // Decode stall: everything must hold.
    $display("[TB] decode stall");
    push_exp(32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      check32("stall_pc", id_pc, 32'h8);
      check32("stall_instr", id_instr, 32'h0020_0113);
      check32("stall_valid", {31'b0, id_valid}, 32'd1);
      check32("stall_addr", imem_addr, 32'hC);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput();
    step();
    check32("count_three", fetch_count, 32'd3);

    // Redirect coincident with a transfer.
    $display("[TB] aligned redirect");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    checkOutput();
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check32("redir_valid", {31'b0, id_valid}, 32'd0);
    check32("redir_count", fetch_count, 32'd4);
    check32("redir_addr", imem_addr, 32'h40);
    push_exp(32'h40);
    push_exp(32'h44);
    checkOutput();
    step();
    checkOutput();
    step();

    // Misaligned redirect target.
    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h42);
    checkOutput();
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check32("mis_flag", {31'b0, misalign_err}, 32'd1);
    check32("mis_valid", {31'b0, id_valid}, 32'd0);
    check32("mis_addr", imem_addr, 32'h40);
    check32("mis_count", fetch_count, 32'd6);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check32("mis_id_pc", id_pc, 32'h40);
    check32("mis_id_valid", {31'b0, id_valid}, 32'd1);
    step();
    check32("mis_sticky", {31'b0, misalign_err}, 32'd1);
    check32("hold_valid", {31'b0, id_valid}, 32'd1);

    // Reset while an entry is held under stall.
    $display("[TB] mid-run reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check32("mrst_valid", {31'b0, id_valid}, 32'd0);
    check32("mrst_addr", imem_addr, 32'h0);
    check32("mrst_count", fetch_count, 32'd0);
    check32("mrst_misalign", {31'b0, misalign_err}, 32'd0);
    check32("mrst_instr", id_instr, 32'h0000_0013);
    step();
    step();
    check32("idle_valid", {31'b0, id_valid}, 32'd0);
    check32("idle_addr", imem_addr, 32'h0);

    // PC wrap on the high-reset-PC instance.
    $display("[TB] pc wrap");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check32("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    step();
    check32("wrap_latency", {31'b0, w_id_valid}, 32'd0);
    checkOutput();
    step();
    check32("wrap_pc0", w_id_pc, 32'hFFFF_FFF8);
    check32("wrap_instr0", w_id_instr, rom_word(32'hFFFF_FFF8));
    checkOutput();
    step();
    check32("wrap_pc1", w_id_pc, 32'hFFFF_FFFC);
    checkOutput();
    step();
    check32("wrap_pc2", w_id_pc, 32'h0000_0000);
    check32("wrap_instr2", w_id_instr, 32'h0000_0013);
    check32("wrap_addr", w_imem_addr, 32'h4);
    checkOutput();
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check32("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
